// File: rtl/branch_redirect_ctrl_if.sv
// Decode / branch-unit / fetch handshake bundle for the branch redirect controller.
interface branch_redirect_ctrl_if #(
  parameter int TAG_W = 3,
  parameter int CNT_W = 16
);
  logic             dec_valid;
  logic             dec_ready;
  logic             dec_branch;
  logic             dec_jump;
  logic [31:0]      dec_target;
  logic [TAG_W-1:0] br_tag;
  logic             br_res_valid;
  logic [TAG_W-1:0] br_res_tag;
  logic             br_res_taken;
  logic             stall_dispatch;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_ifq;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  // master: decode / branch unit / fetch side
  modport master (
    output dec_valid, dec_branch, dec_jump, dec_target,
           br_res_valid, br_res_tag, br_res_taken,
    input  dec_ready, br_tag, stall_dispatch, redirect_valid, redirect_pc,
           flush_ifq, branch_cnt, taken_cnt
  );

  // slave: the controller
  modport slave (
    input  dec_valid, dec_branch, dec_jump, dec_target,
           br_res_valid, br_res_tag, br_res_taken,
    output dec_ready, br_tag, stall_dispatch, redirect_valid, redirect_pc,
           flush_ifq, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Front-end control-flow sequencer: jumps redirect at once, branches stall dispatch
// until resolved (predicted not-taken) and redirect/flush only when taken.
module branch_redirect_ctrl #(
  parameter int TAG_W        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_redirect_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_RES = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      target_q, target_d;
  logic [31:0]      rpc_q, rpc_d;
  logic             rv_q, rv_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    target_d = target_q;
    rpc_d    = rpc_q;
    rv_d     = 1'b0;
    fcnt_d   = fcnt_q;
    bcnt_d   = bcnt_q;
    tcnt_d   = tcnt_q;
    case (state_q)
      IDLE: begin
        // jump takes priority when both flags are set
        if (bus.dec_valid && bus.dec_jump) begin
          rpc_d   = bus.dec_target;
          rv_d    = 1'b1;
          fcnt_d  = FC_LOAD;
          state_d = FLUSH;
        end else if (bus.dec_valid && bus.dec_branch) begin
          target_d = bus.dec_target;
          tag_d    = tag_q + TAG_W'(1);
          bcnt_d   = bcnt_q + CNT_W'(1);
          state_d  = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (bus.br_res_valid && (bus.br_res_tag == tag_q)) begin
          if (bus.br_res_taken) begin
            tcnt_d  = tcnt_q + CNT_W'(1);
            rpc_d   = target_q;
            rv_d    = 1'b1;
            fcnt_d  = FC_LOAD;
            state_d = FLUSH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = IDLE;
        else              fcnt_d  = fcnt_q - FC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      target_q <= '0;
      rpc_q    <= '0;
      rv_q     <= 1'b0;
      fcnt_q   <= '0;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      rpc_q    <= rpc_d;
      rv_q     <= rv_d;
      fcnt_q   <= fcnt_d;
      bcnt_q   <= bcnt_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign bus.dec_ready      = (state_q == IDLE);
  assign bus.stall_dispatch = (state_q == WAIT_RES) || (state_q == FLUSH);
  assign bus.flush_ifq      = (state_q == FLUSH);
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.br_tag         = tag_q;
  assign bus.branch_cnt     = bcnt_q;
  assign bus.taken_cnt      = tcnt_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboarded random bench for branch_redirect_ctrl; redirects checked by a monitor.
module tb_branch_redirect_ctrl;
  localparam int TAG_W = 3;
  localparam int FC    = 2;
  localparam int CNT_W = 4;   // narrow so counter wrap is reached
  localparam int TMASK = (1 << TAG_W) - 1;
  localparam int CMASK = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] pc;
    int          bc;
    int          tc;
  } redir_t;

  logic clk, rst_n;
  branch_redirect_ctrl_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bif ();

  branch_redirect_ctrl #(.TAG_W(TAG_W), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave)
  );

  int n_cmp = 0, n_err = 0;
  redir_t exp_q[$];
  int m_tag, m_bc, m_tc;   // reference model: outstanding tag and statistics

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every redirect must match the oldest expected one; flush runs last FC cycles
  int  run = 0;
  bit  abort = 1'b0;
  always @(negedge rst_n) abort = 1'b1;
  always @(negedge clk) begin
    if (bif.redirect_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_redirect", 32'd1, 32'd0);
      else begin
        redir_t e;
        e = exp_q.pop_front();
        chk("redirect_pc", bif.redirect_pc, e.pc);
        chk("redirect_bcnt", 32'(bif.branch_cnt), 32'(e.bc));
        chk("redirect_tcnt", 32'(bif.taken_cnt), 32'(e.tc));
        chk("redirect_flush", 32'(bif.flush_ifq), 32'd1);
      end
    end
    if (bif.flush_ifq === 1'b1) run++;
    else begin
      if (run > 0 && !abort) chk("flush_len", 32'(run), 32'(FC));
      run = 0;
      if (rst_n) abort = 1'b0;
    end
  end

  task automatic chk_idle(input string nm);
    chk({nm, "_ready"}, 32'(bif.dec_ready), 32'd1);
    chk({nm, "_stall"}, 32'(bif.stall_dispatch), 32'd0);
    chk({nm, "_flush"}, 32'(bif.flush_ifq), 32'd0);
    chk({nm, "_bcnt"}, 32'(bif.branch_cnt), 32'(m_bc));
    chk({nm, "_tcnt"}, 32'(bif.taken_cnt), 32'(m_tc));
    chk({nm, "_tag"}, 32'(bif.br_tag), 32'(m_tag));
  endtask

  // entered at negedge of the first redirect cycle
  task automatic flush_tail();
    for (int k = 1; k <= FC; k++) begin
      chk("flush_stall", 32'(bif.stall_dispatch), 32'd1);
      chk("flush_ready", 32'(bif.dec_ready), 32'd0);
      chk("flush_ifq", 32'(bif.flush_ifq), 32'd1);
      @(negedge clk);
    end
    chk_idle("post_flush");
  endtask

  // present one instruction at a negedge; returns at negedge after the accepting edge
  task automatic issue(input bit br, input bit jp, input logic [31:0] tgt);
    chk("pre_ready", 32'(bif.dec_ready), 32'd1);
    bif.dec_valid = 1'b1; bif.dec_branch = br; bif.dec_jump = jp; bif.dec_target = tgt;
    if (jp) exp_q.push_back('{pc: tgt, bc: m_bc, tc: m_tc});
    else if (br) begin
      m_tag = (m_tag + 1) & TMASK;
      m_bc  = (m_bc + 1) & CMASK;
    end
    @(posedge clk);
    @(negedge clk);
    bif.dec_valid = 1'b0; bif.dec_branch = 1'b0; bif.dec_jump = 1'b0;
    if (!jp && br) begin
      chk("wait_stall", 32'(bif.stall_dispatch), 32'd1);
      chk("wait_ready", 32'(bif.dec_ready), 32'd0);
      chk("wait_tag", 32'(bif.br_tag), 32'(m_tag));
      chk("wait_bcnt", 32'(bif.branch_cnt), 32'(m_bc));
    end
  endtask

  // waits dly cycles (wrong-tag strobes when noisy), then resolves the outstanding branch
  task automatic resolve(input bit taken, input int dly, input bit noisy, input logic [31:0] tgt);
    for (int i = 0; i < dly; i++) begin
      bif.br_res_valid = noisy;
      bif.br_res_tag   = TAG_W'((m_tag + 1 + i % TMASK) & TMASK);
      bif.br_res_taken = 1'b1;
      @(negedge clk);
      chk("hold_stall", 32'(bif.stall_dispatch), 32'd1);
      chk("hold_ready", 32'(bif.dec_ready), 32'd0);
    end
    bif.br_res_valid = 1'b1; bif.br_res_tag = TAG_W'(m_tag); bif.br_res_taken = taken;
    if (taken) begin
      m_tc = (m_tc + 1) & CMASK;
      exp_q.push_back('{pc: tgt, bc: m_bc, tc: m_tc});
    end
    @(posedge clk);
    @(negedge clk);
    bif.br_res_valid = 1'b0; bif.br_res_taken = 1'b0;
    if (taken) flush_tail();
    else begin
      chk_idle("not_taken");
      chk("not_taken_rv", 32'(bif.redirect_valid), 32'd0);
    end
  endtask

  task automatic idle_strobe();
    bif.br_res_valid = 1'b1; bif.br_res_tag = TAG_W'(m_tag); bif.br_res_taken = 1'b1;
    @(negedge clk);
    bif.br_res_valid = 1'b0;
    chk_idle("idle_strobe");
  endtask

  initial begin
    logic [31:0] t;
    rst_n = 1'b0;
    bif.dec_valid = 1'b0; bif.dec_branch = 1'b0; bif.dec_jump = 1'b0; bif.dec_target = '0;
    bif.br_res_valid = 1'b0; bif.br_res_tag = '0; bif.br_res_taken = 1'b0;
    m_tag = 0; m_bc = 0; m_tc = 0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_rv", 32'(bif.redirect_valid), 32'd0);
    chk("reset_pc", bif.redirect_pc, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // jump
    issue(1'b0, 1'b1, 32'h0000_0100);
    flush_tail();
    // taken branch, resolved after a few cycles
    issue(1'b1, 1'b0, 32'h0000_0040);
    resolve(1'b1, 3, 1'b0, 32'h0000_0040);
    // not-taken branch
    issue(1'b1, 1'b0, 32'h0000_0080);
    resolve(1'b0, 1, 1'b0, 32'h0000_0080);
    // wrong-tag strobe ignored, then correct tag
    issue(1'b1, 1'b0, 32'h0000_1234);
    resolve(1'b1, 2, 1'b1, 32'h0000_1234);
    // strobe while idle, plain instruction pass-through
    idle_strobe();
    issue(1'b0, 1'b0, 32'hdead_beef);
    chk_idle("passthru");
    // tag wrap
    for (int i = 0; i < 8; i++) begin
      t = 32'h2000 + 32'(i * 4);
      issue(1'b1, 1'b0, t);
      resolve(i[0], 0, 1'b0, t);
    end
    // both flags: jump path, no branch counted
    issue(1'b1, 1'b1, 32'h0000_0500);
    flush_tail();

    // reset in the middle of a flush
    issue(1'b0, 1'b1, 32'h0000_0700);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_tag = 0; m_bc = 0; m_tc = 0;
    chk_idle("flush_reset");
    chk("flush_reset_rv", 32'(bif.redirect_valid), 32'd0);
    chk("flush_reset_pc", bif.redirect_pc, 32'd0);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = $urandom_range(0, 5);
      t = $urandom;
      case (kind)
        0: begin issue(1'b0, 1'b0, t); chk_idle("rnd_passthru"); end
        1: begin issue(1'b0, 1'b1, t); flush_tail(); end
        2, 3: begin
          issue(1'b1, 1'b0, t);
          resolve(1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'($urandom_range(0, 1)), t);
        end
        4: begin issue(1'b1, 1'b1, t); flush_tail(); end
        default: idle_strobe();
      endcase
    end

    repeat (2) @(negedge clk);
    chk("redirects_pending", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
